// File: rtl/vec_pkg.sv
// Shared FSM encoding and default geometry for the vector SAD scanner.
package vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_RAM_WIDTH            = 4;
    localparam int DEF_RAM_ADDR_BITS_VECTOR = 6;
    localparam int DEF_VEC_LEN              = 64;

endpackage

// File: rtl/abs_diff.sv
// Unsigned absolute difference |a - b|; the result always fits in W bits.
module abs_diff #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/vector_sad_scan.sv
// Streams a feature vector against a reference-vector memory and returns the sum of absolute differences.
// Optional feature: define SAD_THRESHOLD_EN to add the sad_threshold input and the res_diseased flag.
module vector_sad_scan
    import vec_pkg::*;
#(
    parameter int  RAM_WIDTH            = DEF_RAM_WIDTH,
    parameter int  RAM_ADDR_BITS_VECTOR = DEF_RAM_ADDR_BITS_VECTOR,
    parameter int  VEC_LEN              = DEF_VEC_LEN,
    localparam int ACC_W                = RAM_WIDTH + RAM_ADDR_BITS_VECTOR
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    input  logic                            s_valid,
    input  logic [RAM_WIDTH-1:0]            s_data,
    output logic                            s_ready,
    output logic [RAM_ADDR_BITS_VECTOR-1:0] addr_vector,
    input  logic [RAM_WIDTH-1:0]            ref_data,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [ACC_W-1:0]                res_sad
`ifdef SAD_THRESHOLD_EN
    ,
    input  logic [ACC_W-1:0]                sad_threshold,
    output logic                            res_diseased
`endif
);

    localparam logic [RAM_ADDR_BITS_VECTOR-1:0] LAST_IDX = RAM_ADDR_BITS_VECTOR'(VEC_LEN - 1);

    state_t                          state, state_next;
    logic [RAM_ADDR_BITS_VECTOR-1:0] idx;
    logic [ACC_W-1:0]                acc;
    logic [ACC_W-1:0]                acc_sum;
    logic [RAM_WIDTH-1:0]            diff;
    logic                            accept;
    logic                            last;

    abs_diff #(.W(RAM_WIDTH)) u_abs_diff (
        .a (s_data),
        .b (ref_data),
        .y (diff)
    );

    assign accept  = s_valid && s_ready;
    assign last    = (idx == LAST_IDX);
    assign acc_sum = acc + ACC_W'(diff);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SCAN;
            end
            SCAN: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && last) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Index wraps to 0 on the last element so addr_vector already reads 0 once back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
        end else if (state == IDLE && start) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            acc <= acc_sum;
            idx <= last ? '0 : idx + RAM_ADDR_BITS_VECTOR'(1);
        end
    end

    assign addr_vector = idx;
    assign res_sad     = acc;

`ifdef SAD_THRESHOLD_EN
    // Threshold is sampled together with the final sum and held for the whole DONE phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              res_diseased <= 1'b0;
        else if (state == SCAN && accept && last) res_diseased <= (acc_sum <= sad_threshold);
    end
`endif

endmodule

// File: tb/tb_vector_sad_scan.sv
// Self-checking bench for vector_sad_scan: randomized vectors against a plain-arithmetic SAD model.
module tb_vector_sad_scan;

    localparam int RW    = 4;
    localparam int AB    = 6;
    localparam int N     = 64;
    localparam int ACC_W = RW + AB;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              s_valid = 1'b0;
    logic [RW-1:0]     s_data = '0;
    logic              s_ready;
    logic [AB-1:0]     addr_vector;
    logic [RW-1:0]     ref_data;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [ACC_W-1:0]  res_sad;
`ifdef SAD_THRESHOLD_EN
    logic [ACC_W-1:0]  sad_threshold = '0;
    logic              res_diseased;
`endif

    logic [RW-1:0] ref_mem [N];
    logic [RW-1:0] feat    [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ref_data = ref_mem[addr_vector];

    vector_sad_scan #(
        .RAM_WIDTH            (RW),
        .RAM_ADDR_BITS_VECTOR (AB),
        .VEC_LEN              (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .addr_vector (addr_vector),
        .ref_data    (ref_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sad     (res_sad)
`ifdef SAD_THRESHOLD_EN
        ,
        .sad_threshold (sad_threshold),
        .res_diseased  (res_diseased)
`endif
    );

    function automatic int sad_model();
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int d = int'(feat[i]) - int'(ref_mem[i]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    task automatic fill(input int ref_mode, input int feat_mode);
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = (ref_mode == 0) ? 4'd0 : (ref_mode == 1) ? RW'(i % 16) : RW'($urandom_range(15));
            feat[i]    = (feat_mode == 0) ? 4'd0 : (feat_mode == 1) ? 4'd15 : RW'($urandom_range(15));
        end
    endtask

    // Drives one full scan; records the result without consuming it.
    task automatic do_scan(input bit gaps, output int sad, output bit lat_ok,
                           output int addr_bad, output bit timeout);
        int i = 0;
        int cyc = 0;
        addr_bad = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (i < N && cyc < 2000) begin
            if (addr_vector !== AB'(i)) addr_bad++;
            if (gaps && ($urandom_range(2) == 0)) begin
                s_valid = 1'b0;
                s_data  = RW'($urandom_range(15));
            end else begin
                s_valid = 1'b1;
                s_data  = feat[i];
            end
            if (s_valid && s_ready) i++;
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        timeout = (i < N);
        lat_ok  = (res_valid === 1'b1);
        sad     = int'(res_sad);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk) res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_sad !== '0)     begin errors++; $display("FAIL reset_res_sad got=%0d exp=0", res_sad); end
        checks++; if (addr_vector !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", addr_vector); end
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic run_and_check(input string name, input bit gaps, input int exp);
        int sad, bad;
        bit lat, to;
        do_scan(gaps, sad, lat, bad, to);
        checks++; if (to)         begin errors++; $display("FAIL %s_timeout accepted fewer than %0d elements", name, N); end
        checks++; if (sad !== exp) begin errors++; $display("FAIL %s_sad got=%0d exp=%0d", name, sad, exp); end
        checks++; if (!lat)       begin errors++; $display("FAIL %s_latency res_valid=%b exp=1 one cycle after last accept", name, res_valid); end
        checks++; if (bad !== 0)  begin errors++; $display("FAIL %s_addr got=%0d bad cycles exp=0", name, bad); end
        consume();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle busy got=%b exp=0", name, busy); end
    endtask

    task automatic test_zero();
        fill(0, 0);
        run_and_check("zero", 1'b0, 0);
    endtask

    task automatic test_extremes();
        fill(0, 1);
        checks++; if (sad_model() !== 960) begin errors++; $display("FAIL model_max got=%0d exp=960", sad_model()); end
        run_and_check("max", 1'b0, 960);
        fill(1, 0);
        run_and_check("ramp", 1'b0, 480);
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            fill(2, 2);
            run_and_check("gapless", 1'b0, sad_model());
            run_and_check("gapped", 1'b1, sad_model());
        end
    endtask

    task automatic test_back_pressure();
        int sad, bad, exp;
        bit lat, to;
        fill(2, 2);
        exp = sad_model();
        do_scan(1'b0, sad, lat, bad, to);
        checks++; if (sad !== exp) begin errors++; $display("FAIL bp_sad got=%0d exp=%0d", sad, exp); end
        for (int c = 0; c < 10; c++) begin
            start = c[0];
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || int'(res_sad) !== exp || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d valid=%b sad=%0d busy=%b exp valid=1 sad=%0d busy=1",
                         c, res_valid, res_sad, busy, exp);
            end
        end
        start = 1'b0;
        consume();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || addr_vector !== '0) begin
            errors++;
            $display("FAIL bp_idle valid=%b busy=%b s_ready=%b addr=%0d exp all 0",
                     res_valid, busy, s_ready, addr_vector);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_restart busy got=%b exp=0", busy); end
    endtask

    task automatic test_mid_reset();
        int i = 0;
        int cyc = 0;
        fill(2, 2);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (i < 30 && cyc < 200) begin
            s_valid = 1'b1;
            s_data  = feat[i];
            if (s_ready) i++;
            cyc++;
            @(negedge clk);
        end
        checks++; if (addr_vector !== AB'(30)) begin errors++; $display("FAIL mid_addr got=%0d exp=30", addr_vector); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || res_valid !== 1'b0 || res_sad !== '0 || addr_vector !== '0) begin
            errors++;
            $display("FAIL mid_async busy=%b s_ready=%b valid=%b sad=%0d addr=%0d exp all 0",
                     busy, s_ready, res_valid, res_sad, addr_vector);
        end
        s_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_and_check("after_reset", 1'b1, sad_model());
    endtask

`ifdef SAD_THRESHOLD_EN
    task automatic test_threshold();
        int sad, bad;
        bit lat, to;
        fill(0, 1);
        sad_threshold = ACC_W'(960);
        do_scan(1'b0, sad, lat, bad, to);
        checks++; if (res_diseased !== 1'b1) begin errors++; $display("FAIL thr_960 got=%b exp=1", res_diseased); end
        consume();
        sad_threshold = ACC_W'(959);
        do_scan(1'b0, sad, lat, bad, to);
        checks++; if (res_diseased !== 1'b0) begin errors++; $display("FAIL thr_959 got=%b exp=0", res_diseased); end
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_extremes();
        test_gaps();
        test_back_pressure();
        test_mid_reset();
`ifdef SAD_THRESHOLD_EN
        test_threshold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
